// File: rtl/sdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_pkg
//  Description : Shared definitions for the SD card SPI response receiver:
//                mode encodings, FSM states, data-response status codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdc_pkg;

    // Response type selected when a receive is armed
    localparam logic [1:0] MODE_R1    = 2'd0;
    localparam logic [1:0] MODE_R7    = 2'd1;
    localparam logic [1:0] MODE_DRESP = 2'd2;

    // Receiver state machine
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HUNT  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_BUSY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Data-response token status field
    localparam logic [2:0] DR_ACCEPT = 3'b010;
    localparam logic [2:0] DR_CRC    = 3'b101;
    localparam logic [2:0] DR_WERR   = 3'b110;

    // Width of the deserialiser (R7 is the longest response)
    localparam int SHIFT_W = 40;

    // Total bits per response, start bit included; reserved mode behaves as R1
    function automatic logic [5:0] resp_len(input logic [1:0] mode);
        logic [5:0] len;
        case (mode)
            MODE_R7:    len = 6'd40;
            MODE_DRESP: len = 6'd5;
            default:    len = 6'd8;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdc_bit_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_bit_shifter
//  Description : 40-bit MSB-first shift register with synchronous clear and
//                enable, a saturating bit counter and a flag that marks the
//                next enabled bit as the final bit of the response.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdc_bit_shifter
    import sdc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic               bit_i,
    input  logic [5:0]         len_i,
    output logic [SHIFT_W-1:0] data_o,
    output logic [SHIFT_W-1:0] next_o,
    output logic               last_o
);

    logic [SHIFT_W-1:0] data_q;
    logic [5:0]         cnt_q;

    // Value the register will hold once the current bit is shifted in;
    // the FSM captures results from this so they are ready with the pulse.
    assign next_o = {data_q[SHIFT_W-2:0], bit_i};
    assign data_o = data_q;
    assign last_o = (cnt_q == (len_i - 6'd1));

    // Shift in one bit per enable; the counter saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (en_i) begin
            data_q <= next_o;
            if (cnt_q != 6'h3F) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdc_response_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sdc_response_rx
//  Description : SD card SPI response receiver. Hunts for the start bit on
//                MISO, deserialises R1 / R7 / data-response tokens, waits out
//                the busy phase after an accepted write and reports the
//                result with a single-cycle respValid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdc_response_rx
    import sdc_pkg::*;
#(
    parameter int NCR_BYTES = 8,
    parameter int BUSY_MAX  = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic [1:0]  mode,
    input  logic        sampleEn,
    input  logic        dataFromSdc,
    output logic        respValid,
    output logic [7:0]  respByte,
    output logic [31:0] respExtra,
    output logic        accepted,
    output logic        timeout,
    output logic        busy,
    output logic        idle
);

    localparam int c_HUNT_LIMIT = NCR_BYTES * 8;
    localparam int c_HUNT_W     = $clog2(c_HUNT_LIMIT + 1);
    localparam int c_BUSY_W     = $clog2(BUSY_MAX + 1);

    localparam logic [c_HUNT_W-1:0] c_HUNT_LAST = c_HUNT_W'(c_HUNT_LIMIT - 1);
    localparam logic [c_BUSY_W-1:0] c_BUSY_LAST = c_BUSY_W'(BUSY_MAX - 1);

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [c_HUNT_W-1:0] hunt_q, hunt_d;
    logic [c_BUSY_W-1:0] bcnt_q, bcnt_d;
    logic [7:0]          byte_q, byte_d;
    logic [31:0]         extra_q, extra_d;
    logic                acc_q, acc_d;
    logic                to_q, to_d;

    logic               w_sh_clr;
    logic               w_sh_en;
    logic [SHIFT_W-1:0] w_sh_data;
    logic [SHIFT_W-1:0] w_sh_next;
    logic               w_sh_last;

    sdc_bit_shifter u_shifter (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (w_sh_clr),
        .en_i   (w_sh_en),
        .bit_i  (dataFromSdc),
        .len_i  (resp_len(mode_q)),
        .data_o (w_sh_data),
        .next_o (w_sh_next),
        .last_o (w_sh_last)
    );

    // State register and result fields; results persist until the next arm
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_R1;
            hunt_q  <= '0;
            bcnt_q  <= '0;
            byte_q  <= '0;
            extra_q <= '0;
            acc_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hunt_q  <= hunt_d;
            bcnt_q  <= bcnt_d;
            byte_q  <= byte_d;
            extra_q <= extra_d;
            acc_q   <= acc_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic: hunt, deserialise, wait out busy, report
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        hunt_d   = hunt_q;
        bcnt_d   = bcnt_q;
        byte_d   = byte_q;
        extra_d  = extra_q;
        acc_d    = acc_q;
        to_d     = to_q;
        w_sh_clr = 1'b0;
        w_sh_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A strobe coinciding with arm is dropped: nothing samples here
                if (arm) begin
                    mode_d   = mode;
                    hunt_d   = '0;
                    bcnt_d   = '0;
                    byte_d   = '0;
                    extra_d  = '0;
                    acc_d    = 1'b0;
                    to_d     = 1'b0;
                    w_sh_clr = 1'b1;
                    state_d  = ST_HUNT;
                end
            end

            ST_HUNT: begin
                if (sampleEn) begin
                    if (dataFromSdc) begin
                        hunt_d = hunt_q + 1'b1;
                        if (hunt_q == c_HUNT_LAST) begin
                            to_d    = 1'b1;
                            byte_d  = 8'hFF;
                            state_d = ST_DONE;
                        end
                    end else begin
                        // Start bit is the MSB of the response
                        w_sh_en = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                if (sampleEn) begin
                    w_sh_en = 1'b1;
                    if (w_sh_last) begin
                        case (mode_q)
                            MODE_R7: begin
                                byte_d  = w_sh_next[39:32];
                                extra_d = w_sh_next[31:0];
                                state_d = ST_DONE;
                            end
                            MODE_DRESP: begin
                                // Token: start, 3-bit status, stop
                                byte_d  = {3'b000, w_sh_next[4:0]};
                                acc_d   = (w_sh_next[3:1] == DR_ACCEPT);
                                state_d = (w_sh_next[3:1] == DR_ACCEPT) ? ST_BUSY : ST_DONE;
                            end
                            default: begin
                                byte_d  = w_sh_next[7:0];
                                state_d = ST_DONE;
                            end
                        endcase
                    end
                end
            end

            ST_BUSY: begin
                if (sampleEn) begin
                    if (dataFromSdc) begin
                        state_d = ST_DONE;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == c_BUSY_LAST) begin
                            to_d    = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign respValid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign idle      = (state_q == ST_IDLE);
    assign respByte  = byte_q;
    assign respExtra = extra_q;
    assign accepted  = acc_q;
    assign timeout   = to_q;

    // Full register contents are only consumed through next_o
    logic w_unused;
    assign w_unused = ^w_sh_data;

endmodule
`default_nettype wire

// File: tb/tb_sdc_response_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdc_response_rx
//  Description : Scoreboard bench for sdc_response_rx. Stimulus pushes the
//                hand-computed response into a queue; monitors pop and compare
//                whenever a DUT pulses respValid. A second instance with
//                BUSY_MAX=16 covers the busy timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdc_response_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic [1:0]  mode;
    logic        sampleEn;
    logic        dataFromSdc;

    logic        respValid, accepted, timeout, busy, idle;
    logic [7:0]  respByte;
    logic [31:0] respExtra;

    logic        rv16, acc16, to16, busy16, idle16;
    logic [7:0]  rb16;
    logic [31:0] rx16;

    sdc_response_rx dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .mode        (mode),
        .sampleEn    (sampleEn),
        .dataFromSdc (dataFromSdc),
        .respValid   (respValid),
        .respByte    (respByte),
        .respExtra   (respExtra),
        .accepted    (accepted),
        .timeout     (timeout),
        .busy        (busy),
        .idle        (idle)
    );

    sdc_response_rx #(.NCR_BYTES(8), .BUSY_MAX(16)) dut16 (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .mode        (mode),
        .sampleEn    (sampleEn),
        .dataFromSdc (dataFromSdc),
        .respValid   (rv16),
        .respByte    (rb16),
        .respExtra   (rx16),
        .accepted    (acc16),
        .timeout     (to16),
        .busy        (busy16),
        .idle        (idle16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic [31:0] x;
        logic        acc;
        logic        to;
    } exp_t;

    exp_t q[$];
    exp_t q16[$];

    int cyc       = 0;
    int checks    = 0;
    int errors    = 0;
    int last_cyc  = 0;
    int rv16_cyc  = -1;
    int busy_seen = 0;
    int t16;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] b, input logic [31:0] x,
                                input logic acc, input logic to);
        exp_t e;
        e.b = b; e.x = x; e.acc = acc; e.to = to;
        return e;
    endfunction

    // Main monitor: field compare plus one-clock latency from the last sample
    always @(negedge clk) begin
        if (busy) busy_seen++;
        if (respValid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got respValid=1 expected no response pending");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("respByte",  {24'd0, respByte}, {24'd0, e.b});
                chk("respExtra", respExtra, e.x);
                chk("accepted",  {31'd0, accepted}, {31'd0, e.acc});
                chk("timeout",   {31'd0, timeout},  {31'd0, e.to});
                chk("latency",   cyc, last_cyc + 1);
            end
        end
    end

    // Monitor for the BUSY_MAX=16 instance
    always @(negedge clk) begin
        if (rv16) begin
            rv16_cyc = cyc;
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp16: got respValid=1 expected no response pending");
            end else begin
                exp_t e;
                e = q16.pop_front();
                chk("respByte16", {24'd0, rb16}, {24'd0, e.b});
                chk("respExtra16", rx16, e.x);
                chk("accepted16", {31'd0, acc16}, {31'd0, e.acc});
                chk("timeout16",  {31'd0, to16},  {31'd0, e.to});
            end
        end
    end

    task automatic do_arm(input logic [1:0] m);
        @(negedge clk);
        arm  = 1'b1;
        mode = m;
        @(negedge clk);
        arm  = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        sampleEn    = 1'b1;
        dataFromSdc = b;
        last_cyc    = cyc;
        @(negedge clk);
        sampleEn    = 1'b0;
        dataFromSdc = 1'b1;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_const(input logic b, input int n);
        for (int i = 0; i < n; i++) send_bit(b);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (q.size() != 0 || q16.size() != 0); i++) @(negedge clk);
        checks++;
        if (q.size() != 0 || q16.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d/%0d pending expected 0/0", name, q.size(), q16.size());
            q.delete();
            q16.delete();
        end
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_idle"},      {31'd0, idle},      32'd1);
        chk({name, "_respValid"}, {31'd0, respValid}, 32'd0);
        chk({name, "_busy"},      {31'd0, busy},      32'd0);
        chk({name, "_respByte"},  {24'd0, respByte},  32'd0);
        chk({name, "_respExtra"}, respExtra,          32'd0);
        chk({name, "_accepted"},  {31'd0, accepted},  32'd0);
        chk({name, "_timeout"},   {31'd0, timeout},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        arm         = 1'b0;
        mode        = 2'd0;
        sampleEn    = 1'b0;
        dataFromSdc = 1'b1;
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        reset = 1'b0;

        // R1 after three bytes of ones
        q.push_back(mk(8'h01, 32'd0, 1'b0, 1'b0));
        q16.push_back(mk(8'h01, 32'd0, 1'b0, 1'b0));
        do_arm(2'd0);
        send_const(1'b1, 24);
        send_bits(64'h01, 8);
        drain("r1");

        // R7: R1 byte followed by 32-bit payload
        q.push_back(mk(8'h01, 32'h000001AA, 1'b0, 1'b0));
        q16.push_back(mk(8'h01, 32'h000001AA, 1'b0, 1'b0));
        do_arm(2'd1);
        send_const(1'b1, 3);
        send_bits(64'h01_000001AA, 40);
        drain("r7");
        chk("r7_hold_extra", respExtra, 32'h000001AA);

        // Hunt timeout after 64 ones
        q.push_back(mk(8'hFF, 32'd0, 1'b0, 1'b1));
        q16.push_back(mk(8'hFF, 32'd0, 1'b0, 1'b1));
        do_arm(2'd0);
        send_const(1'b1, 64);
        drain("hunt_to");
        chk("hunt_hold_timeout", {31'd0, timeout}, 32'd1);
        pulse_reset();
        chk_cleared("post_reset");

        // Data response accepted, 20 busy bits then release
        q.push_back(mk(8'h05, 32'd0, 1'b1, 1'b0));
        q16.push_back(mk(8'h05, 32'd0, 1'b1, 1'b1));
        do_arm(2'd2);
        busy_seen = 0;
        send_bits(64'b1100101, 7);
        send_const(1'b0, 20);
        send_bit(1'b1);
        drain("dresp_acc");
        chk("busy_cycles", busy_seen, 42);
        chk("dresp_hold_acc", {31'd0, accepted}, 32'd1);

        // CRC reject: no busy phase, immediate report
        q.push_back(mk(8'h0B, 32'd0, 1'b0, 1'b0));
        q16.push_back(mk(8'h0B, 32'd0, 1'b0, 1'b0));
        do_arm(2'd2);
        busy_seen = 0;
        send_bits(64'b01011, 5);
        drain("dresp_crc");
        chk("crc_no_busy", busy_seen, 0);

        // Busy timeout on the BUSY_MAX=16 instance; default instance released later
        q.push_back(mk(8'h05, 32'd0, 1'b1, 1'b0));
        q16.push_back(mk(8'h05, 32'd0, 1'b1, 1'b1));
        do_arm(2'd2);
        send_bit(1'b1);
        send_bits(64'b00101, 5);
        send_const(1'b0, 16);
        t16 = last_cyc;
        @(negedge clk);
        chk("busy16_to_latency", rv16_cyc, t16 + 1);
        chk("busy_still_high", {31'd0, busy}, 32'd1);
        send_bit(1'b1);
        drain("busy_to");

        // arm coinciding with a strobe: the zero must not become a start bit
        q.push_back(mk(8'h5A, 32'd0, 1'b0, 1'b0));
        q16.push_back(mk(8'h5A, 32'd0, 1'b0, 1'b0));
        @(negedge clk);
        arm = 1'b1; mode = 2'd0; sampleEn = 1'b1; dataFromSdc = 1'b0;
        @(negedge clk);
        arm = 1'b0; sampleEn = 1'b0; dataFromSdc = 1'b1;
        send_bits(64'h5A, 8);
        drain("arm_with_sample");

        // arm outside IDLE (in HUNT and in SHIFT) is ignored
        q.push_back(mk(8'h3C, 32'd0, 1'b0, 1'b0));
        q16.push_back(mk(8'h3C, 32'd0, 1'b0, 1'b0));
        do_arm(2'd0);
        send_const(1'b1, 2);
        do_arm(2'd2);
        send_bits(64'b0011, 4);
        do_arm(2'd1);
        send_bits(64'b1100, 4);
        drain("arm_busy");

        // Reset in the middle of an R7 payload; no response may follow
        do_arm(2'd1);
        send_bits(64'h01, 8);
        send_bits(64'hAB, 8);
        pulse_reset();
        chk_cleared("mid_reset");
        send_const(1'b0, 10);
        chk("mid_reset_stay_idle", {31'd0, idle}, 32'd1);

        // Recovery: immediate R1 with no leading ones
        q.push_back(mk(8'h01, 32'd0, 1'b0, 1'b0));
        q16.push_back(mk(8'h01, 32'd0, 1'b0, 1'b0));
        do_arm(2'd3);
        send_bits(64'h01, 8);
        drain("recover");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdc_response_rx.md
# sdc_response_rx

Serial receive stage for the SD card SPI link. It sits directly downstream of the card's MISO line, next to the SD card writer, and consumes the bits the card returns after each command or data block. It finds the start of a response, deserialises it, and reports it on a single-cycle valid pulse. The writer's state machine uses that report to advance or abort. Three response types are supported: R1, R7 (R1 plus 32 bits) and the data-response token followed by busy.

## Interface
- `NCR_BYTES`, default 8: maximum all-ones bytes to hunt through before a response start; exceeding it flags a timeout.
- `BUSY_MAX`, default 65535: maximum bit times the card may hold the line low in busy before a timeout.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `arm`  in  1  one-cycle pulse that starts a receive; honoured only in IDLE.
- `mode`  in  2  latched on `arm`: 0 = R1, 1 = R7, 2 = data response + busy, 3 = reserved (treated as R1).
- `sampleEn`  in  1  one-cycle strobe per SPI bit time.
- `dataFromSdc`  in  1  card MISO, already synchronised; valid when `sampleEn`=1.
- `respValid`  out  1  one-cycle pulse: result fields are valid.
- `respByte`  out  8  R1 byte, or the 5-bit data-response token zero-extended.
- `respExtra`  out  32  trailing R7 payload, MSB first; 0 in other modes.
- `accepted`  out  1  data-response status == 3'b010; valid with `respValid`.
- `timeout`  out  1  hunt or busy limit exceeded; valid with `respValid`.
- `busy`  out  1  high while in BUSY state.
- `idle`  out  1  high in IDLE.

## Operation
- The state machine has five states: IDLE, HUNT, SHIFT, BUSY, DONE.
- **IDLE**
  - `arm` latches `mode`, clears the bit counters and the shift register, and moves to HUNT.
  - A `sampleEn` arriving in the same cycle as `arm` is discarded.
- **HUNT**
  - On each `sampleEn`, a sampled 1 increments the hunt counter.
  - A sampled 0 is the start bit. Shift it in as the MSB and move to SHIFT.
  - In R1/R7 modes the start bit is bit 7 of R1. In data mode it is token bit 4.
  - When the hunt counter reaches `NCR_BYTES`*8 ones, set `timeout`, set `respByte`=8'hFF and go to DONE.
- **SHIFT**
  - Each `sampleEn` shifts `dataFromSdc` in, MSB first.
  - Total bit counts including the start bit: R1 = 8, R7 = 40, data mode = 5.
  - The remaining bits are a 3-bit status followed by a stop bit.
  - On the last bit:
    - R1/R7 go to DONE.
    - Data mode sets `accepted` = (status == 3'b010). If accepted it goes to BUSY; otherwise it goes to DONE.
- **BUSY**
  - On each `sampleEn`, a sampled 0 increments the busy counter.
  - A sampled 1 goes to DONE.
  - When the busy counter reaches `BUSY_MAX`, set `timeout` and go to DONE.
- **DONE**
  - Drive `respValid`=1 for exactly one cycle, then return to IDLE.
- Result fields hold their values until the next `arm` clears them.
- Counters are sized to their limits (the hunt counter is ceil(log2(`NCR_BYTES`*8+1)) bits) and never wrap.
- `arm` is ignored in every state other than IDLE.
- Reset, including mid-receive:
  - Return to IDLE.
  - All outputs go to 0, except `idle`=1.
  - The shift register and counters are cleared.

## Timing
- The final bit is sampled in cycle N. The state moves to DONE at edge N+1, and `respValid` is high during cycle N+1.
- Latency from the last sampled bit to `respValid` is therefore one clock.
- `busy` rises in the cycle after the stop bit is sampled. It falls in the same cycle `respValid` rises.
- Back-to-back operation is supported: `arm` may be issued in the cycle after `respValid`, because the block is in IDLE by then.
- Minimum spacing between `sampleEn` strobes is 1 cycle; continuous `sampleEn` is legal.

## Structure
- A shared package `sdc_pkg` holds:
  - the `mode` encodings (`MODE_R1`, `MODE_R7`, `MODE_DRESP`);
  - the state enumeration;
  - the data-response status constants (`DR_ACCEPT`=3'b010, `DR_CRC`=3'b101, `DR_WERR`=3'b110).
- One natural sub-module, `sdc_bit_shifter`: a 40-bit MSB-first shift register with clear and enable, plus a bit counter and a terminal-count flag.
- The FSM and the timeout counters remain in the top module.

## Test plan
- **R1 found:** `mode`=0; drive 3 bytes of 1s, then 8'h01 → `respValid` one cycle after the 8th bit, `respByte`=8'h01, `timeout`=0.
- **R7 found:** `mode`=1; drive 8'h01 followed by 32'h000001AA → `respByte`=8'h01, `respExtra`=32'h000001AA.
- **Hunt timeout:** `mode`=0; drive 64 ones → `timeout`=1 and `respByte`=8'hFF, with `respValid` on the cycle after the 64th sample.
- **Data accepted with busy:** `mode`=2; drive 1,1,0,0,1,0,1, then 20 zeros, then 1 → `accepted`=1 and `respByte`=5'b00101. `busy` is high for the 21 sample periods from the stop bit to the release bit. `respValid` follows the release bit.
- **CRC reject and busy timeout:**
  - Token status 3'b101 → `accepted`=0, no BUSY, immediate `respValid`.
  - With `BUSY_MAX`=16 and the line held low → `timeout`=1 after 16 low samples.
- **Reset and arm corner cases:**
  - Assert `reset` mid-SHIFT in R7 → next cycle `idle`=1 and all outputs 0.
  - `arm` together with `sampleEn` → that sample is not counted.
  - `arm` while not in IDLE → ignored.
